// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: states, opcodes and control encodings shared by the control unit
package multicycle_control_fsm_pkg;
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, LW_WB, MEM_WR,
        RTYPE_EX, R_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
    typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10} alu_src_b_t;
    typedef enum logic [1:0] {PC_ALU = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10} pc_src_t;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_src_t    pc_source;
    } ctrl_t;
    function automatic logic op_valid(logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: IR/datapath inputs to the control unit and its decoded control outputs
interface multicycle_control_fsm_if #(parameter int CNT_W = 32);
    logic             run;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IRWrite;
    logic             Branch;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             RegWrite;
    logic             RegDst;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;
    logic             busy;
    modport master (
        output run, opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, IRWrite, Branch, MemRead, MemWrite, MemtoReg,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, instr_count, busy
    );
    modport slave (
        input  run, opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, IRWrite, Branch, MemRead, MemWrite, MemtoReg,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, instr_count, busy
    );
endinterface

// File: rtl/multicycle_control_fsm_control_decode.sv
// control_decode: Moore map from control state to the datapath control vector
module control_decode
    import multicycle_control_fsm_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            DECODE: ctrl.alu_src_b = SRCB_IMM;
            MEM_ADDR, ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEM_RD: ctrl.mem_read = 1'b1;
            LW_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WR: ctrl.mem_write = 1'b1;
            RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ADDI_WB: ctrl.reg_write = 1'b1;
            BRANCH: begin
                ctrl.branch        = 1'b1;
                ctrl.pc_write_cond = 1'b1;
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PC_BRANCH;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle main control sequencer with memory stall and retire counter
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    multicycle_control_fsm_if.slave bus
);
    state_t           state, state_nx;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] count;
    logic             illegal;
    logic             retire;
    logic             bad_op;

    control_decode u_decode (.state(state), .ctrl(ctrl));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count + CNT_W'(retire);
            illegal <= bad_op;
        end
    end

    // run is only consulted when an instruction ends or is discarded, so one in flight always completes
    always_comb begin
        bad_op   = (state == DECODE) && !op_valid(bus.opcode);
        retire   = (state inside {LW_WB, R_WB, ADDI_WB, BRANCH, JUMP}) || (state == MEM_WR && bus.mem_ready);
        state_nx = state;
        case (state)
            IDLE:     state_nx = bus.run ? FETCH : IDLE;
            FETCH:    state_nx = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_nx = RTYPE_EX;
                    OP_LW, OP_SW: state_nx = MEM_ADDR;
                    OP_BEQ:       state_nx = BRANCH;
                    OP_ADDI:      state_nx = ADDI_EX;
                    OP_J:         state_nx = JUMP;
                    default:      state_nx = bus.run ? FETCH : IDLE;
                endcase
            end
            MEM_ADDR: state_nx = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   state_nx = bus.mem_ready ? LW_WB : MEM_RD;
            RTYPE_EX: state_nx = R_WB;
            ADDI_EX:  state_nx = ADDI_WB;
            default:  ;
        endcase
        if (retire) state_nx = bus.run ? FETCH : IDLE;
    end

    // the PC advances by 4 only once the fetch has actually returned the instruction
    assign bus.PCWrite     = ctrl.pc_write | (state == FETCH && bus.mem_ready);
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.Branch      = ctrl.branch;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.illegal_op  = illegal;
    assign bus.instr_count = count;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle checks of the multi-cycle control unit
module tb_multicycle_control_fsm;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;
    // {PCWrite,PCWriteCond,IRWrite,Branch,MemRead,MemWrite,MemtoReg,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    localparam logic [15:0] V_IDLE      = 16'h0000;
    localparam logic [15:0] V_FETCH_W   = 16'h2810;
    localparam logic [15:0] V_FETCH_R   = 16'hA810;
    localparam logic [15:0] V_DECODE    = 16'h0020;
    localparam logic [15:0] V_MEM_ADDR  = 16'h0060;
    localparam logic [15:0] V_MEM_RD    = 16'h0800;
    localparam logic [15:0] V_LW_WB     = 16'h0300;
    localparam logic [15:0] V_MEM_WR    = 16'h0400;
    localparam logic [15:0] V_RTYPE_EX  = 16'h0048;
    localparam logic [15:0] V_R_WB      = 16'h0180;
    localparam logic [15:0] V_ADDI_EX   = 16'h0060;
    localparam logic [15:0] V_ADDI_WB   = 16'h0100;
    localparam logic [15:0] V_BRANCH    = 16'h5045;
    localparam logic [15:0] V_JUMP      = 16'h8002;

    typedef struct packed {
        logic        run;
        logic        rdy;
        logic        zero;
        logic [5:0]  op;
        logic [15:0] vec;
        logic        ill;
        logic        busy;
        logic [3:0]  inc;
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ctrl_vec;
    logic [3:0]  exp_cnt = 4'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    multicycle_control_fsm_if #(.CNT_W(4)) bus ();
    multicycle_control_fsm #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign ctrl_vec = {bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.Branch, bus.MemRead, bus.MemWrite,
                       bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource};

    function automatic row_t r(logic run, logic rdy, logic zero, logic [5:0] op, logic [15:0] vec,
                               logic ill, logic busy, logic [3:0] inc);
        return '{run, rdy, zero, op, vec, ill, busy, inc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.run = 1'b0;
        #1;
        n_checks++;
        if (ctrl_vec !== V_IDLE) begin n_fail++; $display("FAIL reset_ctrl: got %h want %h", ctrl_vec, V_IDLE); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.instr_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.instr_count); end
        n_checks++;
        if (bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.illegal_op); end
        step();
        step();
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: busy got %b want 0", bus.busy); end
    endtask

    task automatic test_lw();
        row_t t[7];
        t = '{r(1,1,0,OP_LW,V_IDLE,0,0,0),     r(0,1,0,OP_LW,V_FETCH_R,0,1,0), r(0,1,0,OP_LW,V_DECODE,0,1,0),
              r(0,1,0,OP_LW,V_MEM_ADDR,0,1,0), r(0,1,0,OP_LW,V_MEM_RD,0,1,0),  r(0,1,0,OP_LW,V_LW_WB,0,1,0),
              r(0,1,0,OP_LW,V_IDLE,0,0,1)};
        foreach (t[i]) begin
            bus.run = t[i].run; bus.mem_ready = t[i].rdy; bus.zero = t[i].zero; bus.opcode = t[i].op;
            #1;
            n_checks++;
            if (ctrl_vec !== t[i].vec || bus.illegal_op !== t[i].ill || bus.busy !== t[i].busy ||
                bus.instr_count !== 4'(exp_cnt + t[i].inc)) begin
                n_fail++;
                $display("FAIL lw row %0d: got vec=%h ill=%b busy=%b cnt=%0d want vec=%h ill=%b busy=%b cnt=%0d", i,
                         ctrl_vec, bus.illegal_op, bus.busy, bus.instr_count, t[i].vec, t[i].ill, t[i].busy, 4'(exp_cnt + t[i].inc));
            end
            step();
        end
        exp_cnt = exp_cnt + t[6].inc;
    endtask

    task automatic test_sw_stall();
        row_t t[9];
        t = '{r(1,1,0,OP_SW,V_IDLE,0,0,0),     r(0,1,0,OP_SW,V_FETCH_R,0,1,0), r(0,1,0,OP_SW,V_DECODE,0,1,0),
              r(0,1,0,OP_SW,V_MEM_ADDR,0,1,0), r(0,0,0,OP_SW,V_MEM_WR,0,1,0),  r(0,0,0,OP_SW,V_MEM_WR,0,1,0),
              r(0,0,0,OP_SW,V_MEM_WR,0,1,0),   r(0,1,0,OP_SW,V_MEM_WR,0,1,0),  r(0,1,0,OP_SW,V_IDLE,0,0,1)};
        foreach (t[i]) begin
            bus.run = t[i].run; bus.mem_ready = t[i].rdy; bus.zero = t[i].zero; bus.opcode = t[i].op;
            #1;
            n_checks++;
            if (ctrl_vec !== t[i].vec || bus.illegal_op !== t[i].ill || bus.busy !== t[i].busy ||
                bus.instr_count !== 4'(exp_cnt + t[i].inc)) begin
                n_fail++;
                $display("FAIL sw_stall row %0d: got vec=%h ill=%b busy=%b cnt=%0d want vec=%h ill=%b busy=%b cnt=%0d", i,
                         ctrl_vec, bus.illegal_op, bus.busy, bus.instr_count, t[i].vec, t[i].ill, t[i].busy, 4'(exp_cnt + t[i].inc));
            end
            step();
        end
        exp_cnt = exp_cnt + t[8].inc;
    endtask

    task automatic test_branch();
        row_t t[10];
        t = '{r(1,1,1,OP_BEQ,V_IDLE,0,0,0),   r(0,1,1,OP_BEQ,V_FETCH_R,0,1,0), r(0,1,1,OP_BEQ,V_DECODE,0,1,0),
              r(0,1,1,OP_BEQ,V_BRANCH,0,1,0), r(1,1,0,OP_BEQ,V_IDLE,0,0,1),    r(0,1,0,OP_BEQ,V_FETCH_R,0,1,1),
              r(0,1,0,OP_BEQ,V_DECODE,0,1,1), r(0,1,0,OP_BEQ,V_BRANCH,0,1,1),  r(0,1,0,OP_BEQ,V_IDLE,0,0,2),
              r(0,1,0,OP_BEQ,V_IDLE,0,0,2)};
        foreach (t[i]) begin
            bus.run = t[i].run; bus.mem_ready = t[i].rdy; bus.zero = t[i].zero; bus.opcode = t[i].op;
            #1;
            n_checks++;
            if (ctrl_vec !== t[i].vec || bus.illegal_op !== t[i].ill || bus.busy !== t[i].busy ||
                bus.instr_count !== 4'(exp_cnt + t[i].inc)) begin
                n_fail++;
                $display("FAIL branch row %0d: got vec=%h ill=%b busy=%b cnt=%0d want vec=%h ill=%b busy=%b cnt=%0d", i,
                         ctrl_vec, bus.illegal_op, bus.busy, bus.instr_count, t[i].vec, t[i].ill, t[i].busy, 4'(exp_cnt + t[i].inc));
            end
            step();
        end
        exp_cnt = exp_cnt + t[9].inc;
    endtask

    task automatic test_addi();
        row_t t[6];
        t = '{r(1,1,0,OP_ADDI,V_IDLE,0,0,0),    r(0,1,0,OP_ADDI,V_FETCH_R,0,1,0), r(0,1,0,OP_ADDI,V_DECODE,0,1,0),
              r(0,1,0,OP_ADDI,V_ADDI_EX,0,1,0), r(0,1,0,OP_ADDI,V_ADDI_WB,0,1,0), r(0,1,0,OP_ADDI,V_IDLE,0,0,1)};
        foreach (t[i]) begin
            bus.run = t[i].run; bus.mem_ready = t[i].rdy; bus.zero = t[i].zero; bus.opcode = t[i].op;
            #1;
            n_checks++;
            if (ctrl_vec !== t[i].vec || bus.illegal_op !== t[i].ill || bus.busy !== t[i].busy ||
                bus.instr_count !== 4'(exp_cnt + t[i].inc)) begin
                n_fail++;
                $display("FAIL addi row %0d: got vec=%h ill=%b busy=%b cnt=%0d want vec=%h ill=%b busy=%b cnt=%0d", i,
                         ctrl_vec, bus.illegal_op, bus.busy, bus.instr_count, t[i].vec, t[i].ill, t[i].busy, 4'(exp_cnt + t[i].inc));
            end
            step();
        end
        exp_cnt = exp_cnt + t[5].inc;
    endtask

    task automatic test_illegal_then_jump();
        row_t t[9];
        t = '{r(1,1,0,OP_BAD,V_IDLE,0,0,0),    r(1,1,0,OP_BAD,V_FETCH_R,0,1,0), r(1,1,0,OP_BAD,V_DECODE,0,1,0),
              r(1,0,0,OP_BAD,V_FETCH_W,1,1,0), r(0,0,0,OP_J,V_FETCH_W,0,1,0),   r(0,1,0,OP_J,V_FETCH_R,0,1,0),
              r(0,1,0,OP_J,V_DECODE,0,1,0),    r(0,1,0,OP_J,V_JUMP,0,1,0),      r(0,1,0,OP_J,V_IDLE,0,0,1)};
        foreach (t[i]) begin
            bus.run = t[i].run; bus.mem_ready = t[i].rdy; bus.zero = t[i].zero; bus.opcode = t[i].op;
            #1;
            n_checks++;
            if (ctrl_vec !== t[i].vec || bus.illegal_op !== t[i].ill || bus.busy !== t[i].busy ||
                bus.instr_count !== 4'(exp_cnt + t[i].inc)) begin
                n_fail++;
                $display("FAIL illegal row %0d: got vec=%h ill=%b busy=%b cnt=%0d want vec=%h ill=%b busy=%b cnt=%0d", i,
                         ctrl_vec, bus.illegal_op, bus.busy, bus.instr_count, t[i].vec, t[i].ill, t[i].busy, 4'(exp_cnt + t[i].inc));
            end
            step();
        end
        exp_cnt = exp_cnt + t[8].inc;
    endtask

    task automatic test_reset_mid_write();
        bus.opcode = OP_SW; bus.mem_ready = 1'b1; bus.run = 1'b1;
        step();
        bus.run = 1'b0;
        step();
        step();
        bus.mem_ready = 1'b0;
        step();
        n_checks++;
        if (bus.MemWrite !== 1'b1) begin n_fail++; $display("FAIL rst_pre_memwrite: got %b want 1", bus.MemWrite); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 4'd0;
        n_checks++;
        if (ctrl_vec !== V_IDLE) begin n_fail++; $display("FAIL rst_mid_ctrl: got %h want %h", ctrl_vec, V_IDLE); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.instr_count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", bus.instr_count); end
        bus.mem_ready = 1'b1;
        step();
        n_checks++;
        if (bus.MemWrite !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_stays_idle: MemWrite=%b busy=%b want 0 0", bus.MemWrite, bus.busy);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [15:0] seq[4];
        seq = '{V_FETCH_R, V_DECODE, V_RTYPE_EX, V_R_WB};
        bus.opcode = OP_RTYPE; bus.mem_ready = 1'b1; bus.run = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 4; j++) begin
                bus.run = !(k == 15 && j == 3);
                #1;
                n_checks++;
                if (ctrl_vec !== seq[j] || bus.instr_count !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL rtype instr %0d cycle %0d: got vec=%h cnt=%0d want vec=%h cnt=%0d",
                             k, j, ctrl_vec, bus.instr_count, seq[j], exp_cnt);
                end
                step();
            end
            exp_cnt = exp_cnt + 4'd1;
        end
        n_checks++;
        if (ctrl_vec !== V_IDLE || bus.busy !== 1'b0 || bus.instr_count !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_idle: got vec=%h busy=%b cnt=%0d want vec=0000 busy=0 cnt=0",
                     ctrl_vec, bus.busy, bus.instr_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.run = 1'b0; bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_branch();
        test_addi();
        test_illegal_then_jump();
        test_reset_mid_write();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle main control unit that sequences the shared branch/data-memory datapath across FETCH, DECODE, EXECUTE, MEM and WRITEBACK steps. It decodes the 6-bit opcode and drives one Moore-decoded control vector per state, including Branch, MemRead, MemWrite and MemtoReg. It stalls on a memory-ready handshake and counts retired instructions. It sits between the instruction register and the datapath control inputs.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
run  input  1  level; leaving IDLE requires run=1
opcode  input  6  instruction[31:26], valid from DECODE onward
zero  input  1  ALU zero flag from the datapath, sampled in BRANCH
mem_ready  input  1  memory access completes this cycle
PCWrite  output  1  unconditional PC update
PCWriteCond  output  1  PC update if zero=1
IRWrite  output  1  latch instruction
Branch  output  1  branch-compare cycle
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
MemtoReg  output  1  1 selects memory data for writeback
RegWrite  output  1  register file write enable
RegDst  output  1  1 selects rd, 0 selects rt
ALUSrcA  output  1  0 selects PC, 1 selects reg1
ALUSrcB  output  2  00 reg2, 01 const 4, 10 sign-extended imm
ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
PCSource  output  2  00 ALU result, 01 branch target, 10 jump target
illegal_op  output  1  one-cycle pulse on an undefined opcode
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W
busy  output  1  state != IDLE

Behaviour:
- Control outputs are a pure function of state (Moore). Only PCWriteCond combines with zero in the datapath.
- Outputs not listed for a state are 0.
- Reset (rst=1 at a rising edge), including mid-instruction: state=IDLE, instr_count=0, illegal_op=0, all control outputs 0. No memory write may be asserted in the cycle after reset.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. PCWrite=1 only in the cycle where mem_ready=1.
  - Hold while mem_ready=0. IRWrite stays 1 while held.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch-target precompute). Next state by opcode:
  - 000000 -> RTYPE_EX
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 001000 -> ADDI_EX
  - 000010 -> JUMP
  - any other opcode -> FETCH with illegal_op=1 for one cycle; not counted as retired.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1. Hold until mem_ready=1, then go to LW_WB.
- LW_WB: RegWrite=1, MemtoReg=1, RegDst=0. Retire, then go to FETCH.
- MEM_WR: MemWrite=1. Hold until mem_ready=1, then retire and go to FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Retire, then go to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0. Retire, then go to FETCH.
- BRANCH: Branch=1, PCWriteCond=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. Retire, then go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Retire, then go to FETCH.
- Retire = instr_count+1 on the exit edge of the final state. 2^CNT_W-1 wraps to 0.
- run=0 is checked only on entry to FETCH: from a retiring state or an illegal opcode, go to IDLE instead. An instruction in flight always completes.
- Latency with mem_ready tied to 1: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3.

Decomposition:
- Shared package:
  - state enumeration: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, LW_WB, MEM_WR, RTYPE_EX, R_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOp, ALUSrcB and PCSource encodings
- Single sub-module control_decode: combinational map from state to control vector, reused by the verification model.

Test Plan:
- rst=1 asserted in MEM_WR -> next cycle state IDLE, MemWrite=0, instr_count=0.
- run=1, mem_ready=1, opcode=100011 -> FETCH, DECODE, MEM_ADDR, MEM_RD, LW_WB; MemtoReg=1 and RegWrite=1 in cycle 5; instr_count 0->1.
- opcode=101011 with mem_ready low for 3 cycles in MEM_WR -> MemWrite held 4 cycles, single retire, RegWrite never 1.
- opcode=000100 with zero=1, then repeated with zero=0 -> BRANCH has PCWriteCond=1, PCSource=01, ALUOp=01; each is 3 cycles; count +2.
- opcode=111111 -> illegal_op pulses 1 cycle after DECODE, return to FETCH, instr_count unchanged.
- CNT_W=4, 16 R-type instructions -> instr_count wraps 15->0; run dropped mid-R_WB -> instruction completes, then IDLE with busy=0.
